// File: rtl/itdiv.sv
// itdiv: iterative restoring divider, one quotient bit per clock, MSB first.
// Quotient bits shift into the vacated LSBs of the dividend register, so when
// the last iteration ends that register holds the quotient.
module itdiv #(
  parameter int SIZE = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] N,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q,
  output logic [SIZE-1:0] R,
  output logic            fin,
  output logic            busy,
  output logic            dz
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] dvd_q, dvd_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] r_q, r_d;
  logic            fin_q, fin_d;
  logic            busy_q, busy_d;
  logic            dz_q, dz_d;

  logic [SIZE:0]   trial;
  logic [SIZE+1:0] diff;
  logic            no_borrow;
  logic [SIZE-1:0] dvd_nx;
  logic [SIZE:0]   p_nx;

  // One restoring step: shift in the next dividend bit and try subtracting
  // the divisor. The carry out of T + ~{0,D} + 1 is set when T >= D.
  always_comb begin
    trial     = {p_q[SIZE-1:0], dvd_q[SIZE-1]};
    diff      = {1'b0, trial} + {2'b01, ~dvs_q} + (SIZE + 2)'(1);
    no_borrow = diff[SIZE+1];
    dvd_nx    = {dvd_q[SIZE-2:0], no_borrow};
    p_nx      = no_borrow ? diff[SIZE:0] : trial;
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          dvd_d   = N;
          dvs_d   = D;
          p_d     = '0;
          cnt_d   = '0;
          dz_d    = (D == '0);
          busy_d  = 1'b1;
          fin_d   = 1'b0;
        end
      end
      S_RUN: begin
        dvd_d = dvd_nx;
        p_d   = p_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SIZE - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          q_d     = dvd_nx;
          r_d     = p_nx[SIZE-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        fin_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign fin  = fin_q;
  assign busy = busy_q;
  assign dz   = dz_q;

endmodule
